alu_unit: RTL and testbench

- Parameterised N-bit integer ALU with registered outputs.
- Supports 22 operations selected by a 5-bit opcode: arithmetic, bitwise logic, single-bit shift/rotate and unsigned compare.
- Produces an N-bit result, a 2N-bit extended result (full product for multiply), and carry and overflow flags.
- Sits as the execute-stage datapath block of a simple processor or test harness.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_shifter.sv | 36 +++
 rtl/alu_unit.sv | 146 ++++++++++++++
 tb/tb_alu_unit.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Opcode map and shared types for the execute-stage ALU.
package alu_pkg;

    localparam int OPW = 5;

    localparam logic [OPW-1:0] OP_ADD  = 5'b00000;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00001;
    localparam logic [OPW-1:0] OP_INC  = 5'b00010;
    localparam logic [OPW-1:0] OP_DEC  = 5'b00011;
    localparam logic [OPW-1:0] OP_MUL  = 5'b00100;
    localparam logic [OPW-1:0] OP_OR   = 5'b00101;
    localparam logic [OPW-1:0] OP_AND  = 5'b00110;
    localparam logic [OPW-1:0] OP_XOR  = 5'b00111;
    localparam logic [OPW-1:0] OP_NOR  = 5'b01000;
    localparam logic [OPW-1:0] OP_NAND = 5'b01001;
    localparam logic [OPW-1:0] OP_XNOR = 5'b01010;
    localparam logic [OPW-1:0] OP_NOT  = 5'b01011;
    localparam logic [OPW-1:0] OP_LSL  = 5'b01100;
    localparam logic [OPW-1:0] OP_LSR  = 5'b01101;
    localparam logic [OPW-1:0] OP_ASR  = 5'b01110;
    localparam logic [OPW-1:0] OP_ROL  = 5'b01111;
    localparam logic [OPW-1:0] OP_ROR  = 5'b10000;
    localparam logic [OPW-1:0] OP_EQ   = 5'b10001;
    localparam logic [OPW-1:0] OP_GT   = 5'b10010;
    localparam logic [OPW-1:0] OP_LT   = 5'b10011;
    localparam logic [OPW-1:0] OP_GE   = 5'b10100;
    localparam logic [OPW-1:0] OP_LE   = 5'b10101;

    typedef enum logic [1:0] {
        SM_LOGIC  = 2'd0,
        SM_ARITH  = 2'd1,
        SM_ROTATE = 2'd2
    } shift_mode_e;

endpackage

// File: rtl/alu_shifter.sv
// Single-bit shift/rotate unit; the bit leaving the word is the carry-out.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] din,
    input  shift_mode_e  mode,
    input  logic         left,
    output logic [N-1:0] dout,
    output logic         cout
);

    logic fill;

    always_comb begin
        fill = 1'b0;
        dout = din;
        cout = 1'b0;
        if (left) begin
            // Arithmetic left shift is identical to logical
            fill = (mode == SM_ROTATE) ? din[N-1] : 1'b0;
            dout = {din[N-2:0], fill};
            cout = din[N-1];
        end else begin
            unique case (mode)
                SM_ROTATE: fill = din[0];
                SM_ARITH:  fill = din[N-1];
                default:   fill = 1'b0;
            endcase
            dout = {fill, din[N-1:1]};
            cout = din[0];
        end
    end

endmodule

// File: rtl/alu_unit.sv
// N-bit integer ALU with one-cycle registered results and flags.
module alu_unit
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   num1,
    input  logic [N-1:0]   num2,
    input  logic [OPW-1:0] operation,
    output logic [N-1:0]   results,
    output logic [2*N-1:0] xresults,
    output logic           carryflag,
    output logic           overflow
);

    localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] SMAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] SMIN = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] ZERO = '0;

    logic [N-1:0]   res_d, res_q;
    logic [2*N-1:0] xres_d, xres_q;
    logic           carry_d, carry_q;
    logic           ovf_d, ovf_q;

    logic [N:0]     sum, diff, incr;
    logic [2*N-1:0] prod;
    logic [N-1:0]   sh_out;
    logic           sh_cout;
    shift_mode_e    sh_mode;
    logic           sh_left;
    logic           ext_set;

    assign sum  = {1'b0, num1} + {1'b0, num2};
    assign diff = {1'b0, num1} - {1'b0, num2};
    assign incr = {1'b0, num1} + {1'b0, ONE};
    assign prod = {{N{1'b0}}, num1} * {{N{1'b0}}, num2};

    always_comb begin
        sh_mode = SM_LOGIC;
        sh_left = 1'b0;
        unique case (operation)
            OP_LSL:  sh_left = 1'b1;
            OP_ASR:  sh_mode = SM_ARITH;
            OP_ROL: begin
                sh_mode = SM_ROTATE;
                sh_left = 1'b1;
            end
            OP_ROR:  sh_mode = SM_ROTATE;
            default: ;
        endcase
    end

    alu_shifter #(.N(N)) u_shifter (
        .din  (num1),
        .mode (sh_mode),
        .left (sh_left),
        .dout (sh_out),
        .cout (sh_cout)
    );

    always_comb begin
        res_d   = '0;
        xres_d  = '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        ext_set = 1'b0;
        unique case (operation)
            OP_ADD: begin
                res_d   = sum[N-1:0];
                xres_d  = {{(N-1){1'b0}}, sum};
                ext_set = 1'b1;
                carry_d = sum[N];
                ovf_d   = (num1[N-1] == num2[N-1]) &&
                          (res_d[N-1] != num1[N-1]);
            end
            OP_SUB: begin
                res_d   = diff[N-1:0];
                carry_d = diff[N];
                ovf_d   = (num1[N-1] != num2[N-1]) &&
                          (res_d[N-1] != num1[N-1]);
            end
            OP_INC: begin
                res_d   = incr[N-1:0];
                xres_d  = {{(N-1){1'b0}}, incr};
                ext_set = 1'b1;
                carry_d = incr[N];
                ovf_d   = (num1 == SMAX);
            end
            OP_DEC: begin
                res_d   = num1 - ONE;
                carry_d = (num1 == ZERO);
                ovf_d   = (num1 == SMIN);
            end
            OP_MUL: begin
                res_d   = prod[N-1:0];
                xres_d  = prod;
                ext_set = 1'b1;
                carry_d = |prod[2*N-1:N];
                ovf_d   = |prod[2*N-1:N];
            end
            OP_OR:   res_d = num1 | num2;
            OP_AND:  res_d = num1 & num2;
            OP_XOR:  res_d = num1 ^ num2;
            OP_NOR:  res_d = ~(num1 | num2);
            OP_NAND: res_d = ~(num1 & num2);
            OP_XNOR: res_d = ~(num1 ^ num2);
            OP_NOT:  res_d = ~num1;
            OP_LSL, OP_LSR, OP_ASR, OP_ROL, OP_ROR: begin
                res_d   = sh_out;
                carry_d = sh_cout;
            end
            OP_EQ: res_d = {{(N-1){1'b0}}, (num1 == num2)};
            OP_GT: res_d = {{(N-1){1'b0}}, (num1 >  num2)};
            OP_LT: res_d = {{(N-1){1'b0}}, (num1 <  num2)};
            OP_GE: res_d = {{(N-1){1'b0}}, (num1 >= num2)};
            OP_LE: res_d = {{(N-1){1'b0}}, (num1 <= num2)};
            default: ;
        endcase
        if (!ext_set) begin
            xres_d = {{N{1'b0}}, res_d};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            res_q   <= '0;
            xres_q  <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            res_q   <= res_d;
            xres_q  <= xres_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign results   = res_q;
    assign xresults  = xres_q;
    assign carryflag = carry_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_alu_unit.sv
// Vector-table bench for alu_unit at N=8 with an expected-result queue.
module tb_alu_unit;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] num1, num2;
    logic [4:0]   operation;
    logic [N-1:0] results;
    logic [2*N-1:0] xresults;
    logic         carryflag, overflow;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        string       nm;
        logic        rst;
        logic [4:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  r;
        logic [15:0] x;
        logic        c;
        logic        v;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    alu_unit #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .num1      (num1),
        .num2      (num2),
        .operation (operation),
        .results   (results),
        .xresults  (xresults),
        .carryflag (carryflag),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic add(input string nm, input logic rst,
                       input logic [4:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] r,
                       input logic [15:0] x, input logic c,
                       input logic v);
        vec_t t;
        t.nm = nm; t.rst = rst; t.op = op; t.a = a; t.b = b;
        t.r = r; t.x = x; t.c = c; t.v = v;
        vecs.push_back(t);
    endtask

    task automatic check();
        vec_t e;
        tests++;
        if (sb.size() == 0) begin
            failed++;
            $display("FAIL scoreboard: queue empty");
        end else begin
            e = sb.pop_front();
            if (results !== e.r || xresults !== e.x ||
                carryflag !== e.c || overflow !== e.v) begin
                failed++;
                $display("FAIL %s: got r=%h x=%h c=%b v=%b want r=%h x=%h c=%b v=%b",
                         e.nm, results, xresults, carryflag, overflow,
                         e.r, e.x, e.c, e.v);
            end
        end
    endtask

    task automatic apply(input vec_t t);
        @(negedge clk);
        reset     = t.rst;
        num1      = t.a;
        num2      = t.b;
        operation = t.op;
        sb.push_back(t);
        @(posedge clk);
        #1;
        check();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        num1 = '0;
        num2 = '0;
        operation = '0;

        add("reset_state", 1, 5'b00000, 8'hFF, 8'h01, 8'h00, 16'h0000, 0, 0);
        add("add_100_28",  0, 5'b00000, 8'd100, 8'd28, 8'd128, 16'd128, 0, 1);
        add("add_100_200", 0, 5'b00000, 8'd100, 8'd200, 8'd44, 16'd300, 1, 0);
        add("sub_100_28",  0, 5'b00001, 8'd100, 8'd28, 8'd72, 16'd72, 0, 0);
        add("sub_28_100",  0, 5'b00001, 8'd28, 8'd100, 8'd184, 16'd184, 1, 0);
        add("sub_ovf",     0, 5'b00001, 8'h80, 8'h01, 8'h7F, 16'h007F, 0, 1);
        add("inc_5",       0, 5'b00010, 8'd5, 8'd0, 8'd6, 16'd6, 0, 0);
        add("inc_255",     0, 5'b00010, 8'd255, 8'd0, 8'd0, 16'd256, 1, 0);
        add("inc_127",     0, 5'b00010, 8'd127, 8'd0, 8'd128, 16'd128, 0, 1);
        add("dec_5",       0, 5'b00011, 8'd5, 8'd0, 8'd4, 16'd4, 0, 0);
        add("dec_0",       0, 5'b00011, 8'd0, 8'd0, 8'd255, 16'd255, 1, 0);
        add("dec_128",     0, 5'b00011, 8'd128, 8'd0, 8'd127, 16'd127, 0, 1);
        add("mul_10_20",   0, 5'b00100, 8'd10, 8'd20, 8'd200, 16'd200, 0, 0);
        add("mul_255_255", 0, 5'b00100, 8'd255, 8'd255, 8'd1, 16'd65025, 1, 1);
        add("undef_11111", 0, 5'b11111, 8'hFF, 8'hFF, 8'h00, 16'h0000, 0, 0);
        add("or",          0, 5'b00101, 8'hAA, 8'hCC, 8'hEE, 16'h00EE, 0, 0);
        add("and",         0, 5'b00110, 8'hAA, 8'hCC, 8'h88, 16'h0088, 0, 0);
        add("xor",         0, 5'b00111, 8'hAA, 8'hCC, 8'h66, 16'h0066, 0, 0);
        add("nor",         0, 5'b01000, 8'hAA, 8'hCC, 8'h11, 16'h0011, 0, 0);
        add("nand",        0, 5'b01001, 8'hAA, 8'hCC, 8'h77, 16'h0077, 0, 0);
        add("xnor",        0, 5'b01010, 8'hAA, 8'hCC, 8'h99, 16'h0099, 0, 0);
        add("not",         0, 5'b01011, 8'hAA, 8'hCC, 8'h55, 16'h0055, 0, 0);
        add("lsl_93",      0, 5'b01100, 8'h93, 8'hFF, 8'h26, 16'h0026, 1, 0);
        add("lsr_93",      0, 5'b01101, 8'h93, 8'hFF, 8'h49, 16'h0049, 1, 0);
        add("asr_93",      0, 5'b01110, 8'h93, 8'hFF, 8'hC9, 16'h00C9, 1, 0);
        add("rol_93",      0, 5'b01111, 8'h93, 8'hFF, 8'h27, 16'h0027, 1, 0);
        add("ror_93",      0, 5'b10000, 8'h93, 8'hFF, 8'hC9, 16'h00C9, 1, 0);
        add("lsl_7f",      0, 5'b01100, 8'h7F, 8'h00, 8'hFE, 16'h00FE, 0, 0);
        add("asr_42",      0, 5'b01110, 8'h42, 8'h00, 8'h21, 16'h0021, 0, 0);
        add("rol_40",      0, 5'b01111, 8'h40, 8'h00, 8'h80, 16'h0080, 0, 0);
        add("ror_02",      0, 5'b10000, 8'h02, 8'h00, 8'h01, 16'h0001, 0, 0);
        add("eq_20_20",    0, 5'b10001, 8'd20, 8'd20, 8'd1, 16'd1, 0, 0);
        add("eq_20_21",    0, 5'b10001, 8'd20, 8'd21, 8'd0, 16'd0, 0, 0);
        add("gt_30_20",    0, 5'b10010, 8'd30, 8'd20, 8'd1, 16'd1, 0, 0);
        add("gt_10_20",    0, 5'b10010, 8'd10, 8'd20, 8'd0, 16'd0, 0, 0);
        add("lt_10_20",    0, 5'b10011, 8'd10, 8'd20, 8'd1, 16'd1, 0, 0);
        add("lt_20_10",    0, 5'b10011, 8'd20, 8'd10, 8'd0, 16'd0, 0, 0);
        add("ge_25_25",    0, 5'b10100, 8'd25, 8'd25, 8'd1, 16'd1, 0, 0);
        add("ge_10_20",    0, 5'b10100, 8'd10, 8'd20, 8'd0, 16'd0, 0, 0);
        add("le_10_20",    0, 5'b10101, 8'd10, 8'd20, 8'd1, 16'd1, 0, 0);
        add("le_20_10",    0, 5'b10101, 8'd20, 8'd10, 8'd0, 16'd0, 0, 0);
        add("gt_unsigned", 0, 5'b10010, 8'h80, 8'h7F, 8'd1, 16'd1, 0, 0);
        add("undef_10110", 0, 5'b10110, 8'h0F, 8'h0F, 8'h00, 16'h0000, 0, 0);
        add("add_pre_rst", 0, 5'b00000, 8'd1, 8'd2, 8'd3, 16'd3, 0, 0);

        foreach (vecs[i]) apply(vecs[i]);

        // Reset collides with an ADD: it must win, then the op shows up once released
        begin
            vec_t t;
            t.nm = "rst_over_add"; t.rst = 1; t.op = 5'b00000;
            t.a = 8'hFF; t.b = 8'h01;
            t.r = 8'h00; t.x = 16'h0000; t.c = 0; t.v = 0;
            apply(t);
            t.nm = "add_after_rst"; t.rst = 0;
            t.r = 8'h00; t.x = 16'h0100; t.c = 1; t.v = 0;
            apply(t);
            t.nm = "sub_follow"; t.op = 5'b00001;
            t.a = 8'd5; t.b = 8'd7;
            t.r = 8'hFE; t.x = 16'h00FE; t.c = 1; t.v = 0;
            apply(t);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
